// File: rtl/crop_norm_multi.sv
// Multi-ROI crop/normalise: buffers NUM_ROI windows of one frame, then streams each ROI out scaled to full range.
// Optional build macro CROP_NORM_MINMAX_EN adds per-ROI minimum tracking and (pix-min)/(max-min) normalisation.
module crop_norm_multi #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10,
  parameter int NUM_ROI         = 2,
  localparam int RW             = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ap_start,
  output logic                                  ap_ready,
  output logic                                  ap_done,
  output logic                                  ap_idle,
  input  logic [NUM_ROI*$clog2(IN_COLS)-1:0]    crop_x0,
  input  logic [NUM_ROI*$clog2(IN_ROWS)-1:0]    crop_y0,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]            s_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0]            m_axis_tdata,
  output logic                                  m_axis_tlast,
  output logic [RW-1:0]                         m_axis_tuser
);

  localparam int W     = PIXEL_BIT_WIDTH;
  localparam int XW    = $clog2(IN_COLS);
  localparam int YW    = $clog2(IN_ROWS);
  localparam int DEPTH = OUT_ROWS * OUT_COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (W > 1) ? $clog2(W) : 1;

  localparam logic [W-1:0]  MAXVAL    = '1;
  localparam logic [XW-1:0] X_MAX     = XW'(IN_COLS - OUT_COLS);
  localparam logic [YW-1:0] Y_MAX     = YW'(IN_ROWS - OUT_ROWS);
  localparam logic [XW:0]   X_SPAN    = (XW+1)'(OUT_COLS);
  localparam logic [YW:0]   Y_SPAN    = (YW+1)'(OUT_ROWS);
  localparam logic [XW-1:0] COL_LAST  = XW'(IN_COLS - 1);
  localparam logic [YW-1:0] ROW_LAST  = YW'(IN_ROWS - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [RW-1:0] ROI_LAST  = RW'(NUM_ROI - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_FETCH,
    S_DIV,
    S_EMIT
  } state_t;

  state_t state;

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [NUM_ROI-1:0][XW-1:0] x0_q;
  logic [NUM_ROI-1:0][YW-1:0] y0_q;
  logic [NUM_ROI-1:0][AW-1:0] wptr;
  logic [NUM_ROI-1:0][W-1:0]  max_q;
`ifdef CROP_NORM_MINMAX_EN
  logic [NUM_ROI-1:0][W-1:0]  min_q;
`endif
  logic [NUM_ROI-1:0][W-1:0]  rd_q;
  logic [NUM_ROI-1:0]         hit;

  logic [RW-1:0] roi;
  logic [AW-1:0] addr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem, dlo, quot, den_q;
  logic          zero_q, sat_q;

  logic [W-1:0] mem [NUM_ROI][DEPTH];

  logic beat;
  assign beat = s_axis_tvalid && s_axis_tready;

  // A pixel lands in every ROI whose window covers the current (row, col).
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_ROI; k++) begin
      hit[k] = beat
            && ({1'b0, col} >= {1'b0, x0_q[k]}) && ({1'b0, col} < ({1'b0, x0_q[k]} + X_SPAN))
            && ({1'b0, row} >= {1'b0, y0_q[k]}) && ({1'b0, row} < ({1'b0, y0_q[k]} + Y_SPAN));
    end
  end

  // NOTE: the ROI buffers have no reset so they map onto plain block RAM; stale contents are never read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ROI; k++) begin
      if (hit[k]) mem[k][wptr[k]] <= s_axis_tdata;
      if (state == S_FETCH) rd_q[k] <= mem[k][addr];
    end
  end

  // Divider operands: the first DIV cycle loads straight from the RAM word, later cycles iterate the registers.
  logic [W-1:0]   num_c, den_c, den_in, dlo_in, rem_in, quot_in, rem_n, quot_n, result;
  logic [2*W-1:0] prod;
  logic [W:0]     rs, diff;
  logic           first, ge;

  always_comb begin
`ifdef CROP_NORM_MINMAX_EN
    num_c = rd_q[roi] - min_q[roi];
    den_c = max_q[roi] - min_q[roi];
`else
    num_c = rd_q[roi];
    den_c = max_q[roi];
`endif
    prod    = {num_c, {W{1'b0}}} - {{W{1'b0}}, num_c};
    first   = (cnt == '0);
    rem_in  = first ? prod[2*W-1:W] : rem;
    dlo_in  = first ? prod[W-1:0]   : dlo;
    den_in  = first ? den_c         : den_q;
    quot_in = first ? '0            : quot;
    rs      = {rem_in, dlo_in[W-1]};
    diff    = rs - {1'b0, den_in};
    ge      = ~diff[W];
    rem_n   = ge ? diff[W-1:0] : rs[W-1:0];
    quot_n  = {quot_in[W-2:0], ge};
    result  = zero_q ? '0 : (sat_q ? MAXVAL : quot);
  end

  // NOTE: all state below updates with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ap_ready      <= 1'b0;
      ap_done       <= 1'b0;
      ap_idle       <= 1'b1;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      col           <= '0;
      row           <= '0;
      x0_q          <= '0;
      y0_q          <= '0;
      wptr          <= '0;
      max_q         <= '0;
`ifdef CROP_NORM_MINMAX_EN
      min_q         <= '1;
`endif
      roi           <= '0;
      addr          <= '0;
      cnt           <= '0;
      rem           <= '0;
      dlo           <= '0;
      quot          <= '0;
      den_q         <= '0;
      zero_q        <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      ap_ready <= 1'b0;
      ap_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            for (int k = 0; k < NUM_ROI; k++) begin
              x0_q[k] <= (crop_x0[k*XW +: XW] > X_MAX) ? X_MAX : crop_x0[k*XW +: XW];
              y0_q[k] <= (crop_y0[k*YW +: YW] > Y_MAX) ? Y_MAX : crop_y0[k*YW +: YW];
            end
            wptr          <= '0;
            max_q         <= '0;
`ifdef CROP_NORM_MINMAX_EN
            min_q         <= '1;
`endif
            col           <= '0;
            row           <= '0;
            ap_ready      <= 1'b1;
            ap_idle       <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (beat) begin
            for (int k = 0; k < NUM_ROI; k++) begin
              if (hit[k]) begin
                wptr[k] <= wptr[k] + 1'b1;
                if (s_axis_tdata > max_q[k]) max_q[k] <= s_axis_tdata;
`ifdef CROP_NORM_MINMAX_EN
                if (s_axis_tdata < min_q[k]) min_q[k] <= s_axis_tdata;
`endif
              end
            end
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row           <= '0;
                s_axis_tready <= 1'b0;
                roi           <= '0;
                addr          <= '0;
                state         <= S_FETCH;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_FETCH: begin
          cnt   <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          rem  <= rem_n;
          dlo  <= {dlo_in[W-2:0], 1'b0};
          quot <= quot_n;
          if (first) begin
            den_q  <= den_c;
            zero_q <= (den_c == '0);
            sat_q  <= (prod[2*W-1:W] >= den_c);
          end
          if (cnt == CNT_LAST) state <= S_EMIT;
          else cnt <= cnt + 1'b1;
        end
        S_EMIT: begin
          if (!m_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= result;
            m_axis_tlast  <= (addr == ADDR_LAST);
            m_axis_tuser  <= roi;
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            state         <= S_FETCH;
            if (addr == ADDR_LAST) begin
              addr <= '0;
              if (roi == ROI_LAST) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
                state   <= S_IDLE;
              end else begin
                roi <= roi + 1'b1;
              end
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crop_norm_multi.sv
// Directed bench for crop_norm_multi on an 8x8 ramp frame with two 4x4 ROIs.
module tb_crop_norm_multi;

  localparam int W  = 10;
  localparam int IR = 8;
  localparam int IC = 8;
  localparam int OR = 4;
  localparam int OC = 4;
  localparam int NR = 2;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int NB = NR * OR * OC;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ap_start = 1'b0;
  logic            ap_ready, ap_done, ap_idle;
  logic [NR*XW-1:0] crop_x0 = '0;
  logic [NR*YW-1:0] crop_y0 = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [W-1:0]    s_axis_tdata = '0;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b0;
  logic [W-1:0]    m_axis_tdata;
  logic            m_axis_tlast;
  logic [0:0]      m_axis_tuser;

  crop_norm_multi #(
    .PIXEL_BIT_WIDTH(W), .IN_ROWS(IR), .IN_COLS(IC),
    .OUT_ROWS(OR), .OUT_COLS(OC), .NUM_ROI(NR)
  ) dut (
    .clk(clk), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .crop_x0(crop_x0), .crop_y0(crop_y0),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (ap_done === 1'b1) done_cnt <= done_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] got_d [NB];
  logic         got_l [NB];
  logic         got_u [NB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame pixel source: 0 = ramp row*8+col, 1 = all zero, 2 = all full-scale.
  function automatic int pix_of(input int mode, input int idx);
    if (mode == 0) return idx;
    if (mode == 1) return 0;
    return 1023;
  endfunction

  // Reference value for beat b of a ramp frame; ROI0 sits at (0,0), ROI1 at (x1,y1).
  function automatic int exp_beat(input int b, input int x1, input int y1);
    int r, p, x, y, pix, mn, mx;
    r   = b / (OR*OC);
    p   = b % (OR*OC);
    x   = (r == 1) ? x1 : 0;
    y   = (r == 1) ? y1 : 0;
    pix = (y + p / OC) * IC + x + p % OC;
    mn  = y * IC + x;
    mx  = (y + OR - 1) * IC + x + OC - 1;
`ifdef CROP_NORM_MINMAX_EN
    return (mx == mn) ? 0 : ((pix - mn) * 1023) / (mx - mn);
`else
    return (mx == 0) ? 0 : (pix * 1023) / mx;
`endif
  endfunction

  task automatic set_roi(input int x0a, input int y0a, input int x1, input int y1);
    crop_x0 = {3'(x1), 3'(x0a)};
    crop_y0 = {3'(y1), 3'(y0a)};
  endtask

  task automatic start_job(input string name);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    check({name, "_ap_ready"}, ap_ready, 1);
    check({name, "_capture_tready"}, s_axis_tready, 1);
    check({name, "_idle_low"}, ap_idle, 0);
  endtask

  task automatic send_frame(input int mode, input int npix, output int last_cyc);
    int i, guard;
    logic accept;
    i = 0;
    guard = 0;
    while (i < npix && guard < 2000) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = W'(pix_of(mode, i));
      accept = s_axis_tready;
      @(negedge clk);
      guard++;
      if (accept) i++;
    end
    s_axis_tvalid = 1'b0;
    last_cyc = cyc;
    if (guard >= 2000) check("input_accept_timeout", s_axis_tready, 1);
  endtask

  task automatic collect(input string name, input int mode, input int x1, input int y1,
                         input int stall_beat, input int last_in);
    int bad, lat_bad, unstable, hs, rise, n, e, done0;
    bad = 0; lat_bad = 0; unstable = 0; hs = 0;
    done0 = done_cnt;
    for (int b = 0; b < NB; b++) begin
      n = 0;
      while (m_axis_tvalid !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        check({name, "_tvalid_timeout"}, m_axis_tvalid, 1);
        return;
      end
      rise = cyc;
      if (b == 0) check({name, "_first_latency"}, rise - last_in, W + 2);
      else if (rise - hs != W + 2) lat_bad++;
      got_d[b] = m_axis_tdata;
      got_l[b] = m_axis_tlast;
      got_u[b] = m_axis_tuser;
      if (b == stall_beat) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== got_d[b] ||
              m_axis_tlast !== got_l[b] || m_axis_tuser !== got_u[b]) unstable++;
        end
      end
      m_axis_tready = 1'b1;
      @(negedge clk);
      hs = cyc;
      m_axis_tready = 1'b0;
    end
    check({name, "_ap_done"}, ap_done, 1);
    check({name, "_idle_at_done"}, ap_idle, 1);
    for (int b = 0; b < NB; b++) begin
      e = (mode == 1) ? 0 : exp_beat(b, x1, y1);
      if (got_d[b] !== W'(e)) bad++;
      if (got_l[b] !== ((b % (OR*OC)) == (OR*OC - 1))) bad++;
      if (got_u[b] !== 1'(b / (OR*OC))) bad++;
    end
    check({name, "_stream_mismatches"}, bad, 0);
    check({name, "_cadence_errors"}, lat_bad, 0);
    if (stall_beat >= 0) check({name, "_stall_unstable"}, unstable, 0);
    @(negedge clk);
    check({name, "_done_pulses"}, done_cnt - done0, 1);
    check({name, "_done_cleared"}, ap_done, 0);
  endtask

  int last_in;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ap_ready", ap_ready, 0);
    check("rst_ap_done", ap_done, 0);
    check("rst_ap_idle", ap_idle, 1);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tuser", m_axis_tuser, 0);
    reset = 1'b0;
    @(negedge clk);

    // Ramp frame, ROI0 (0,0), ROI1 (4,4).
    set_roi(0, 0, 4, 4);
    start_job("s1");
    send_frame(0, IR*IC, last_in);
    check("s1_tready_after_frame", s_axis_tready, 0);
    collect("s1", 0, 4, 4, -1, last_in);
    check("s1_beat0", got_d[0], 0);
    check("s1_beat5", got_d[5], 341);
    check("s1_beat15", got_d[15], 1023);
    check("s1_beat31", got_d[31], 1023);
`ifdef CROP_NORM_MINMAX_EN
    check("s1_roi1_beat0", got_d[16], 0);
    check("s1_roi1_beat1", got_d[17], 37);
`else
    check("s1_roi1_beat0", got_d[16], 584);
`endif
    check("s1_tuser0", got_u[0], 0);
    check("s1_tuser16", got_u[16], 1);
    check("s1_tlast15", got_l[15], 1);
    check("s1_tlast31", got_l[31], 1);
    check("s1_tlast14", got_l[14], 0);

    // All-zero frame: every quotient goes through the den=0 path.
    start_job("zero");
    send_frame(1, IR*IC, last_in);
    collect("zero", 1, 4, 4, -1, last_in);
    check("zero_beat20", got_d[20], 0);

    // Out-of-range ROI1 origin is clamped to (4,4).
    set_roi(0, 0, 7, 6);
    start_job("clamp");
    send_frame(0, IR*IC, last_in);
    collect("clamp", 0, 4, 4, -1, last_in);
    check("clamp_roi1_beat15", got_d[31], 1023);

    // Backpressure on beat 3.
    set_roi(0, 0, 4, 4);
    start_job("stall");
    send_frame(0, IR*IC, last_in);
    collect("stall", 0, 4, 4, 3, last_in);

    // Reset partway into a full-scale frame, then a clean ramp frame.
    start_job("abort");
    send_frame(2, 20, last_in);
    reset = 1'b1;
    @(negedge clk);
    check("abort_idle", ap_idle, 1);
    check("abort_s_tready", s_axis_tready, 0);
    check("abort_m_tvalid", m_axis_tvalid, 0);
    reset = 1'b0;
    @(negedge clk);
    start_job("restart");
    send_frame(0, IR*IC, last_in);
    collect("restart", 0, 4, 4, -1, last_in);
    check("restart_beat5", got_d[5], 341);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crop_norm_multi.md
# crop_norm_multi

Multi-ROI successor to the single-window crop/normalise stage, with on-chip ROI buffering.
- Accepts one full Mono frame from the sequentializer as an AXI-Stream pixel stream.
- Crops `NUM_ROI` independent windows of `OUT_ROWS`×`OUT_COLS` and tracks the per-ROI peak (and optionally minimum).
- Buffers each ROI internally, then streams the normalised ROIs out back-to-back, tagged by ROI index, to the downstream inference stage.
- Counts rows/columns internally; no external pixel counters are needed.

## Interface
Parameters:
- `PIXEL_BIT_WIDTH`, 10: input and output pixel width; `MAXVAL` = 2^`PIXEL_BIT_WIDTH`−1.
- `IN_ROWS`, 20: input frame height.
- `IN_COLS`, 20: input frame width.
- `OUT_ROWS`, 10: ROI height (≤ `IN_ROWS`).
- `OUT_COLS`, 10: ROI width (≤ `IN_COLS`).
- `NUM_ROI`, 2: number of ROIs (≥1). `RW` = max(1, $clog2(`NUM_ROI`)).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `ap_start` in 1: frame-job request.
- `ap_ready` out 1: 1-cycle pulse when a start is accepted.
- `ap_done` out 1: 1-cycle pulse after the final output beat.
- `ap_idle` out 1: high in IDLE.
- `crop_x0` in `NUM_ROI`*$clog2(`IN_COLS`): packed left columns; ROI k occupies slice k.
- `crop_y0` in `NUM_ROI`*$clog2(`IN_ROWS`): packed top rows.
- `s_axis_tvalid` in 1; `s_axis_tready` out 1; `s_axis_tdata` in `PIXEL_BIT_WIDTH`: raster-order frame input.
- `m_axis_tvalid` out 1; `m_axis_tready` in 1; `m_axis_tdata` out `PIXEL_BIT_WIDTH`: normalised pixel.
- `m_axis_tlast` out 1: last pixel of each ROI.
- `m_axis_tuser` out `RW`: ROI index of the current beat.

## Operation
States: IDLE → CAPTURE → FETCH → DIV → EMIT → (FETCH | IDLE).

- IDLE:
  - `ap_idle`=1.
  - On `ap_start`: latch all coordinates, pulse `ap_ready`, clear per-ROI max to 0 (and min to `MAXVAL`), go to CAPTURE.
  - Coordinate clamping at latch: x0 > `IN_COLS`−`OUT_COLS` is clamped to `IN_COLS`−`OUT_COLS`; y0 is clamped the same way against `IN_ROWS`−`OUT_ROWS`.
- CAPTURE:
  - `s_axis_tready`=1.
  - Each handshake advances the internal col/row counters (col wraps at `IN_COLS`−1).
  - For every ROI whose window contains the pixel: write it to that ROI's buffer (one RAM per ROI, depth `OUT_ROWS`*`OUT_COLS`, raster order) and update that ROI's max/min.
  - Overlapping ROIs each receive the pixel.
  - After the `IN_ROWS`*`IN_COLS`-th handshake, go to FETCH with ROI=0, addr=0.
- FETCH: 1 cycle; issue the RAM read for the current ROI/addr.
- DIV:
  - Compute `out = floor(num*MAXVAL/den)` with a restoring divider, one quotient bit per cycle, exactly `PIXEL_BIT_WIDTH` cycles.
  - Default mode: num = pix, den = max.
  - If den = 0, the result is 0.
  - Intermediate width is 2*`PIXEL_BIT_WIDTH`; the result saturates at `MAXVAL`.
- EMIT:
  - Hold `m_axis_tvalid`=1 with data/tlast/tuser stable until `m_axis_tready`.
  - On handshake: advance addr. At addr wrap, advance ROI.
  - After the last beat of ROI `NUM_ROI`−1, pulse `ap_done` and go to IDLE; otherwise go to FETCH.
- `ap_start` outside IDLE is ignored.
- Reset mid-operation: return to IDLE in the next cycle. Buffer contents are don't-care; statistics are cleared on the next start.

## Timing
- Reset values: `ap_ready`=0, `ap_done`=0, `ap_idle`=1, `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tuser`=0.
- `ap_ready` is asserted in the cycle after the `ap_start` sample. CAPTURE begins in that same cycle.
- `s_axis_tready` is registered-state driven and has no combinational path from `s_axis_tvalid`.
- First output latency: `m_axis_tvalid` rises exactly `PIXEL_BIT_WIDTH`+2 cycles after the last input handshake (1 FETCH + `PIXEL_BIT_WIDTH` DIV + 1 register).
- Output cadence: each subsequent `m_axis_tvalid` rises `PIXEL_BIT_WIDTH`+2 cycles after the previous output handshake. Processing is strictly serial, with no overlap.
- `ap_done` is asserted in the cycle after the final output handshake. `ap_idle` is 1 in that same cycle.
- Per frame the block emits exactly `NUM_ROI`*`OUT_ROWS`*`OUT_COLS` beats and `NUM_ROI` tlasts.

## Configuration
- `CROP_NORM_MINMAX_EN` defined:
  - Per-ROI min is tracked.
  - Normalisation uses num = pix−min and den = max−min.
  - If max = min, the result is 0.
- Undefined:
  - No min registers or subtractor are built.
  - num = pix, den = max.

## Test plan
All scenarios use `IN_ROWS`=`IN_COLS`=8, `OUT_ROWS`=`OUT_COLS`=4, `NUM_ROI`=2. The input ramp is pix = row*8+col.
- ROI0 (0,0), ROI1 (4,4), default mode → ROI0 beat0 = 0, beat15 = 1023, beat5 (pix 9) = 341, tuser=0. ROI1 beat0 (pix 36) = 584, beat15 = 1023, tuser=1. tlast on beats 15 and 31. Exactly one `ap_done`.
- Same stimulus with `CROP_NORM_MINMAX_EN` → ROI1 beat0 = 0, beat1 (pix 37) = 37, beat15 = 1023.
- All-zero frame → 32 beats, all 0 (den=0 path). `ap_done` asserted.
- ROI1 x0=7, y0=6 → clamped to (4,4); output is identical to scenario 1.
- Hold `m_axis_tready`=0 for 5 cycles on beat 3 → tdata/tlast/tuser stable throughout. Next tvalid arrives `PIXEL_BIT_WIDTH`+2 = 12 cycles after the handshake.
- Assert `reset` after 20 input pixels, then restart with a new frame → `ap_idle`=1 one cycle after reset. The second frame's outputs match scenario 1, with no residue from the first frame's max.
